// File: rtl/maria_line_ram_if.sv
`default_nettype none
// ============================================================================
// Module      : maria_line_ram_if
// Description : Bus bundle between the sync/DMA side and the Maria line RAM.
//               The master drives timing strobes and pixel writes. The slave
//               returns busy status and the display pixel stream.
// Revision    : 1.0 - initial release
// ============================================================================
interface maria_line_ram_if #(
    parameter int WIDTH = 5
);
    logic             mclk0;
    logic             lrc;
    logic             border;
    logic             vblank;
    logic             kangaroo;
    logic             wr_en;
    logic [7:0]       wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             busy;
    logic [WIDTH-1:0] pix_data;
    logic             pix_valid;

    modport master (
        output mclk0, lrc, border, vblank, kangaroo, wr_en, wr_addr, wr_data,
        input  busy, pix_data, pix_valid
    );

    modport slave (
        input  mclk0, lrc, border, vblank, kangaroo, wr_en, wr_addr, wr_data,
        output busy, pix_data, pix_valid
    );
endinterface
`default_nettype wire

// File: rtl/maria_line_ram.sv
`default_nettype none
// ============================================================================
// Module      : maria_line_ram
// Description : Double-buffered 160-entry line RAM. One bank is filled by
//               pixel writes while the other bank is shifted out and cleared
//               behind the beam. The two banks swap roles on lrc.
// Revision    : 1.0 - initial release
// ============================================================================
module maria_line_ram #(
    parameter int WIDTH  = 5,
    parameter int PIXELS = 160
) (
    input  wire logic       clk,
    input  wire logic       reset_n,
    maria_line_ram_if.slave bus
);
    localparam logic [7:0] c_LAST = 8'(PIXELS - 1);

    localparam logic [0:0] S_CLEAR = 1'b0;
    localparam logic [0:0] S_RUN   = 1'b1;

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic             w_busy;

    logic [7:0]       r_clr_addr;
    logic [7:0]       r_rd_addr;
    logic             r_wbank;      // 0: bank A takes writes, 1: bank B does
    logic             r_phase;      // 0: fetch pixel, 1: clear entry and advance
    logic [WIDTH-1:0] r_pix_data;
    logic             r_pix_valid;

    logic [WIDTH-1:0] r_bank_a [0:PIXELS-1];
    logic [WIDTH-1:0] r_bank_b [0:PIXELS-1];

    logic             w_clearing;
    logic             w_run;
    logic             w_window;
    logic             w_tick;
    logic             w_swap;
    logic             w_step;
    logic             w_clr_rd;
    logic             w_wr_ok;
    logic [WIDTH-1:0] w_rd_word;

    assign w_clearing = reset_n && (r_state == S_CLEAR);
    assign w_run      = reset_n && (r_state == S_RUN);
    assign w_window   = !bus.border && !bus.vblank;
    assign w_tick     = w_run && bus.mclk0;
    assign w_swap     = w_tick && bus.lrc;
    // A swap takes priority over the readout step on the same colour clock
    assign w_step     = w_tick && w_window && !bus.lrc;
    assign w_clr_rd   = w_step && r_phase;
    // Colour index 0 is transparent unless kangaroo mode stores it
    assign w_wr_ok    = w_run && bus.wr_en && (bus.wr_addr <= c_LAST) &&
                        ((bus.wr_data[1:0] != 2'b00) || bus.kangaroo);
    // The read bank is always the bank that is not taking writes
    assign w_rd_word  = r_wbank ? r_bank_a[r_rd_addr] : r_bank_b[r_rd_addr];

    // State register: reset always restarts the clear walk
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_CLEAR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: leave CLEAR once the last address has been zeroed
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_CLEAR: if (r_clr_addr == c_LAST) w_state_nxt = S_RUN;
            S_RUN:   w_state_nxt = S_RUN;
            default: w_state_nxt = S_CLEAR;
        endcase
    end

    // FSM outputs: busy flags the post-reset clear
    always_comb begin
        w_busy = (r_state == S_CLEAR);
    end

    // Clear address walks 0..PIXELS-1 once per clk while clearing
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_clr_addr <= 8'd0;
        end else if (w_clearing) begin
            r_clr_addr <= (r_clr_addr == c_LAST) ? 8'd0 : r_clr_addr + 8'd1;
        end
    end

    // Bank A: clear walk, then writes when it is the write bank and display clears otherwise
    always_ff @(posedge clk) begin
        if (w_clearing) begin
            r_bank_a[r_clr_addr] <= '0;
        end else if (w_wr_ok && !r_wbank) begin
            r_bank_a[bus.wr_addr] <= bus.wr_data;
        end else if (w_clr_rd && r_wbank) begin
            r_bank_a[r_rd_addr] <= '0;
        end
    end

    // Bank B: mirror of bank A with the bank roles inverted
    always_ff @(posedge clk) begin
        if (w_clearing) begin
            r_bank_b[r_clr_addr] <= '0;
        end else if (w_wr_ok && r_wbank) begin
            r_bank_b[bus.wr_addr] <= bus.wr_data;
        end else if (w_clr_rd && !r_wbank) begin
            r_bank_b[r_rd_addr] <= '0;
        end
    end

    // Swap and readout sequencing: each pixel is held for two colour clocks
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wbank     <= 1'b0;
            r_rd_addr   <= 8'd0;
            r_phase     <= 1'b0;
            r_pix_data  <= '0;
            r_pix_valid <= 1'b0;
        end else begin
            if (w_swap) begin
                r_wbank   <= ~r_wbank;
                r_rd_addr <= 8'd0;
                r_phase   <= 1'b0;
            end else if (w_step) begin
                r_phase <= ~r_phase;
                if (!r_phase) begin
                    r_pix_data  <= w_rd_word;
                    r_pix_valid <= 1'b1;
                end else if (r_rd_addr != c_LAST) begin
                    r_rd_addr <= r_rd_addr + 8'd1;
                end
            end
            if (w_tick && !w_window) begin
                r_pix_data  <= '0;
                r_pix_valid <= 1'b0;
            end
        end
    end

    assign bus.busy      = w_busy;
    assign bus.pix_data  = r_pix_data;
    assign bus.pix_valid = r_pix_valid;
endmodule
`default_nettype wire

// File: tb/tb_maria_line_ram.sv
`default_nettype none
// ============================================================================
// Module      : tb_maria_line_ram
// Description : Scoreboard bench for maria_line_ram. A line-level model
//               predicts busy and the pixel stream for every clk. A monitor
//               compares the DUT outputs against those predictions.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_maria_line_ram;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    maria_line_ram_if #(.WIDTH(5)) bus ();

    maria_line_ram #(.WIDTH(5), .PIXELS(160)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        bit         busy;
        bit         v;
        logic [4:0] d;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: per-bank pixel arrays, write-bank index and the
    // colour-clock position within the current line.
    logic [4:0] mdl [2][160];
    int         wb;
    int         pos;
    int         clear_left;
    bit         lv;
    logic [4:0] ld;

    task automatic model_reset();
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < 160; i++) mdl[b][i] = 5'd0;
        wb = 0; pos = 0; clear_left = 160; lv = 1'b0; ld = 5'd0;
    endtask

    // One clk of stimulus: drive at negedge, advance the model, queue the expectation
    task automatic step(input bit rn, input bit m, input bit l, input bit bo,
                        input bit vb, input bit we, input logic [7:0] a,
                        input logic [4:0] d, input bit k);
        int rb, ix;
        bit busy_e;
        @(negedge clk);
        reset_n = rn; bus.mclk0 = m; bus.lrc = l; bus.border = bo;
        bus.vblank = vb; bus.wr_en = we; bus.wr_addr = a; bus.wr_data = d;
        bus.kangaroo = k;
        if (!rn) begin
            model_reset();
            busy_e = 1'b1;
        end else if (clear_left > 0) begin
            clear_left--;
            busy_e = (clear_left > 0);
        end else begin
            busy_e = 1'b0;
            if (we && a < 8'd160 && (d[1:0] != 2'b00 || k)) mdl[wb][a] = d;
            if (m) begin
                if (l) begin
                    if (bo || vb) begin lv = 1'b0; ld = 5'd0; end
                    wb = 1 - wb; pos = 0;
                end else if (bo || vb) begin
                    lv = 1'b0; ld = 5'd0;
                end else begin
                    rb = 1 - wb;
                    ix = (pos / 2 > 159) ? 159 : pos / 2;
                    if (pos % 2 == 0) begin lv = 1'b1; ld = mdl[rb][ix]; end
                    else mdl[rb][ix] = 5'd0;
                    pos++;
                end
            end
        end
        q.push_back('{busy: busy_e, v: lv, d: ld});
    endtask

    task automatic idle(input int n, input bit rn);
        for (int i = 0; i < n; i++) step(rn, 0, 0, 1, 0, 0, 8'd0, 5'd0, 0);
    endtask

    task automatic wr(input logic [7:0] a, input logic [4:0] d, input bit k);
        step(1, 0, 0, 1, 0, 1, a, d, k);
    endtask

    task automatic swap();
        step(1, 1, 1, 1, 0, 0, 8'd0, 5'd0, 0);
        idle(1, 1);
    endtask

    task automatic swap_wr(input logic [7:0] a, input logic [4:0] d);
        step(1, 1, 1, 1, 0, 1, a, d, 0);
        idle(1, 1);
    endtask

    // Clear-phase junk: mclk0/lrc toggling with writes, all of which must be ignored
    task automatic junk_clear(input int n);
        for (int i = 0; i < n; i++)
            step(1, (i % 2) == 0, 1, 0, 0, 1, 8'($urandom), 5'($urandom), 1);
    endtask

    // In-window colour clocks followed by one out-of-window colour clock
    task automatic display(input int n, input bit rnd);
        bit we; logic [7:0] a; logic [4:0] d; bit k;
        for (int i = 0; i < 2 * n; i++) begin
            we = rnd ? 1'($urandom) : 1'b0;
            a  = 8'($urandom_range(0, 175));
            d  = 5'($urandom);
            k  = 1'($urandom);
            step(1, (i % 2) == 0, 0, 0, 0, we, a, d, k);
        end
        step(1, 1, 0, 1, 0, 0, 8'd0, 5'd0, 0);
        idle(1, 1);
        step(1, 1, 0, 0, 1, 0, 8'd0, 5'd0, 0);
        idle(1, 1);
    endtask

    // Monitor: every clk edge pops one expectation and checks busy and the pixel output
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                n_tests++;
                if (bus.busy !== e.busy) begin
                    n_fail++;
                    $display("FAIL busy @%0t: got %b, want %b", $time, bus.busy, e.busy);
                end
                n_tests++;
                if (bus.pix_valid !== e.v || bus.pix_data !== e.d) begin
                    n_fail++;
                    $display("FAIL pixel @%0t: got valid=%b data=%h, want valid=%b data=%h",
                             $time, bus.pix_valid, bus.pix_data, e.v, e.d);
                end
            end
        end
    end

    initial begin
        bus.mclk0 = 0; bus.lrc = 0; bus.border = 1; bus.vblank = 0;
        bus.kangaroo = 0; bus.wr_en = 0; bus.wr_addr = 0; bus.wr_data = 0;
        model_reset();

        // Reset, clear with junk, preload junk, then reset mid-line and mid-clear
        idle(3, 0);
        junk_clear(160);
        idle(2, 1);
        for (int i = 0; i < 30; i++) wr(8'($urandom_range(0, 159)), 5'($urandom), 1);
        swap();
        for (int i = 0; i < 30; i++) wr(8'($urandom_range(0, 159)), 5'($urandom), 1);
        display(50, 0);
        idle(2, 0);
        junk_clear(80);
        idle(2, 0);
        junk_clear(160);
        idle(2, 1);

        // Both banks must now display blank
        swap(); display(320, 0);
        swap(); display(320, 0);

        // Single write shown on colour clocks 10-11
        wr(8'd5, 5'h1D, 0);
        swap(); display(320, 0);

        // Transparency with and without kangaroo
        wr(8'd7, 5'h1C, 0);
        swap(); display(320, 0);
        wr(8'd7, 5'h1C, 1);
        swap(); display(320, 0);

        // Out-of-range addresses dropped, last address shown at clocks 318-319
        wr(8'd160, 5'h03, 0);
        wr(8'd255, 5'h03, 0);
        wr(8'd159, 5'h03, 0);
        swap(); display(320, 0);

        // Clear-on-read: same bank comes back blank after two swaps
        wr(8'd0, 5'h0F, 0);
        swap(); display(320, 0);
        swap(); swap(); display(320, 0);

        // Write in the same clk as the swap lands on the next displayed line
        swap_wr(8'd3, 5'h02);
        display(320, 0);

        // Randomised lines: writes, odd window lengths, writes during display
        for (int line = 0; line < 8; line++) begin
            for (int i = 0; i < 40; i++)
                wr(8'($urandom_range(0, 170)), 5'($urandom), 1'($urandom));
            if ($urandom % 2) swap_wr(8'($urandom_range(0, 159)), 5'($urandom));
            else swap();
            display($urandom_range(300, 330), 1);
        end

        idle(4, 1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/maria_line_ram.md
# maria_line_ram

Double-buffered line RAM for the Maria video chip: the DMA/pixel-write engine fills one 160-entry bank while the other bank is shifted out to the palette stage. Bank roles swap on the sync generator's line-reset-count strobe. Entries are cleared to zero as they are displayed, so each line starts blank. Sits directly downstream of the video sync generator, which supplies `lrc`, `border` and `vblank`, and upstream of palette/colour lookup.

## Interface
Parameters:
- `WIDTH`, 5, entry width: bits [4:2] palette, bits [1:0] colour index
- `PIXELS`, 160, visible pixels per line

Ports:
- `clk`  in  1  system clock
- `reset_n`  in  1  synchronous, active-low reset (one clock; reset is synchronous and active-low)
- `mclk0`  in  1  7.16 MHz colour-clock enable; pulses at most once every 2 `clk`
- `lrc`  in  1  line-reset-count strobe from sync; sampled only when `mclk0`=1
- `border`  in  1  high outside the 320-colour-clock display window
- `vblank`  in  1  vertical blank
- `kangaroo`  in  1  1 = colour index 0 writes are stored (not transparent)
- `wr_en`  in  1  pixel write strobe, one write per `clk`
- `wr_addr`  in  8  pixel position 0..159
- `wr_data`  in  WIDTH  pixel value
- `busy`  out  1  post-reset clear in progress
- `pix_data`  out  WIDTH  current display pixel
- `pix_valid`  out  1  `pix_data` belongs to the display window

## Operation
- Two banks, A and B, each `PIXELS` x `WIDTH`. `wbank` selects the write bank; the read bank is always the other one.
- FSM states:
  - CLEAR: entered on reset. Walks `clr_addr` 0..159, zeroing both banks at each address, one address per `clk`. Moves to RUN after address 159.
  - RUN: normal operation.
- Writes (RUN only): a write lands in `wbank[wr_addr]` when all of the following hold:
  - `wr_en`=1
  - `wr_addr` < 160
  - `wr_data[1:0]` != 0 or `kangaroo`=1
  - Otherwise the write is dropped with no side effect.
  - Writes in CLEAR are dropped.
- Swap: on `mclk0`&`lrc` in RUN:
  - `wbank` toggles
  - `rd_addr`←0, `phase`←0
  - A write in the same `clk` goes to the pre-toggle bank.
- Readout: on each `mclk0` with `border`=0, `vblank`=0 and state RUN:
  - `phase`=0: `pix_data`←read bank[`rd_addr`], `pix_valid`←1.
  - `phase`=1: read bank[`rd_addr`]←0, then `rd_addr`←`rd_addr`+1, saturating at 159.
  - `phase` toggles on each such `mclk0`.
  - Each pixel is therefore held for 2 colour clocks: 160 pixels over 320 clocks.
- Outside the window (`border`=1 or `vblank`=1) on `mclk0`:
  - `pix_data`←0, `pix_valid`←0
  - `rd_addr` and `phase` hold; no clearing occurs.
- Reads/clears and writes never touch the same bank in a cycle, so no port conflict arises.
- `rd_addr` stops at 159. If the window is longer than 320 clocks, the last pixel repeats and is re-cleared (harmless).

## Timing
- Reset values (while `reset_n`=0 and the `clk` after): state=CLEAR, `busy`=1, `wbank`=0 (A), `rd_addr`=0, `phase`=0, `clr_addr`=0, `pix_data`=0, `pix_valid`=0.
- `busy`:
  - Remains 1 for exactly 160 `clk` after reset release.
  - Deasserts in the `clk` following the clear of address 159.
- Reset asserted mid-line or mid-clear: the clear restarts from 0; prior bank contents are irrelevant.
- `lrc` and `mclk0` during CLEAR are ignored. No swap occurs and the bank stays A.
- Display latency: `pix_data` updates on the `mclk0` edge of the first in-window colour clock, using RAM contents read in the `clk` cycles before it. No further pipeline stages.
- Write-to-display: data written before the `lrc` swap appears on the following line. Data written after the swap appears one line later.
- `lrc` coinciding with an in-window `mclk0` (not expected from sync): the swap wins. The readout step for that `mclk0` is skipped, and the new read bank starts at pixel 0.

## Test plan
- Clear: release `reset_n` after preloading junk → `busy`=1 for 160 `clk`, then 0; first displayed line is 160 pixels of 0.
- Write/display: write `wr_addr`=5, `wr_data`=0x1D, then pulse `lrc` and open a 320-clock window → `pix_data`=0x1D for colour clocks 10–11 only; all other pixels 0; `pix_valid`=1 for exactly 320 clocks.
- Transparency: write `wr_data`=0x1C at addr 7 with `kangaroo`=0 → pixel 7 stays 0. Repeat with `kangaroo`=1 → pixel 7 = 0x1C.
- Range: write addr 160 and addr 255 with 0x03 → no change to any entry; addr 159 = 0x03 is shown on clocks 318–319.
- Clear-on-read: display a line containing 0x0F at addr 0, perform no writes, swap twice, display again → pixel 0 = 0.
- Same-cycle swap: `wr_en` with addr 3, data 0x02 in the `clk` of `mclk0`&`lrc` → 0x02 is displayed on the line immediately after that swap.
